// File: rtl/wb_slave_pkg.sv
// Shared types and defaults for the Wishbone scratch-memory slave.
package wb_slave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int CNT_W = 8;

   localparam int DEF_DWIDTH      = 32;
   localparam int DEF_AWIDTH      = 32;
   localparam int DEF_MEM_AW      = 4;
   localparam int DEF_WAIT_STATES = 1;

endpackage

// File: rtl/wb_slave_ram.sv
// Byte-lane-enabled synchronous word array; a read issued on the same edge as a write sees the old word.
module wb_slave_ram
   import wb_slave_pkg::*;
#(
   parameter int dwidth = DEF_DWIDTH,
   parameter int mem_aw = DEF_MEM_AW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [mem_aw-1:0]     addr,
   input  logic [dwidth-1:0]     wdata,
   input  logic [dwidth/8-1:0]   sel,
   output logic [dwidth-1:0]     rdata
);

   localparam int NLANE = dwidth / 8;
   localparam int DEPTH = 2 ** mem_aw;

   logic [dwidth-1:0] mem [DEPTH];

   // Array contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NLANE; i++) begin
         if (we && sel[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read port doubles as the bus data register: zero except on the cycle after a read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end else begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave with wait states, err on out-of-range addresses.
// Optional retry termination compiled in with WB_SLAVE_MEM_RTY_EN.
//
// state   | meaning
// IDLE    | waiting for cyc & stb; loads the wait counter
// WAIT    | counting down wait states; abort if cyc/stb drop
// RESP    | one-cycle termination (ack/err/rty), then back to IDLE
module wb_slave_mem
   import wb_slave_pkg::*;
#(
   parameter int dwidth      = DEF_DWIDTH,
   parameter int awidth      = DEF_AWIDTH,
   parameter int mem_aw      = DEF_MEM_AW,
   parameter int wait_states = DEF_WAIT_STATES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [awidth-1:0]     adr,
   input  logic [dwidth-1:0]     din,
   output logic [dwidth-1:0]     dout,
   input  logic                  cyc,
   input  logic                  stb,
   input  logic                  we,
   input  logic [dwidth/8-1:0]   sel,
   output logic                  ack,
   output logic                  err,
   output logic                  rty
);

   localparam int OB = $clog2(dwidth / 8);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              req;
   logic              in_range;
   logic [mem_aw-1:0] word_idx;
   logic              go_resp;
   logic              retry_hit;
   logic              mem_we;
   logic              mem_re;
   logic              rty_q;

   assign req      = cyc & stb;
   assign in_range = ((adr >> (mem_aw + OB)) == '0);
   assign word_idx = mem_aw'(adr >> OB);

   // Asserted on exactly the edge that moves the FSM into RESP.
   always_comb begin
      go_resp = 1'b0;
      unique case (state)
         ST_IDLE: go_resp = req && (wait_states == 0);
         ST_WAIT: go_resp = req && (cnt <= CNT_W'(1));
         default: go_resp = 1'b0;
      endcase
   end

`ifdef WB_SLAVE_MEM_RTY_EN
   logic retry_done;

   assign retry_hit = in_range & ~retry_done;

   // Every in-range termination toggles the flag: rty sets it, the following ack clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         retry_done <= 1'b0;
      end else if (go_resp && in_range) begin
         retry_done <= ~retry_done;
      end
   end
`else
   assign retry_hit = 1'b0;
`endif

   // rst gating drops a write that would otherwise land on the reset edge.
   assign mem_we = go_resp & we  & in_range & ~retry_hit & rst;
   assign mem_re = go_resp & ~we & in_range & ~retry_hit & rst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ack   <= 1'b0;
         err   <= 1'b0;
         rty_q <= 1'b0;
      end else begin
         ack   <= 1'b0;
         err   <= 1'b0;
         rty_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  cnt   <= CNT_W'(wait_states);
                  state <= (wait_states == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt <= CNT_W'(1)) begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         if (go_resp) begin
            if (!in_range) begin
               err <= 1'b1;
            end else if (retry_hit) begin
               rty_q <= 1'b1;
            end else begin
               ack <= 1'b1;
            end
         end
      end
   end

   assign rty = rty_q;

   wb_slave_ram #(
      .dwidth (dwidth),
      .mem_aw (mem_aw)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (word_idx),
      .wdata (din),
      .sel   (sel),
      .rdata (dout)
   );

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: four instances with wait_states 1, 3, 0 and 255.
module tb_wb_slave_mem;

   localparam int NDUT = 4;
   localparam int WS [NDUT] = '{1, 3, 0, 255};
   localparam int TMO = 300;
`ifdef WB_SLAVE_MEM_RTY_EN
   localparam bit RTY_EN = 1'b1;
`else
   localparam bit RTY_EN = 1'b0;
`endif

   localparam logic [2:0] T_ACK = 3'b100;
   localparam logic [2:0] T_ERR = 3'b010;
   localparam logic [2:0] T_RTY = 3'b001;

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [31:0]     adr;
   logic [31:0]     din;
   logic            we;
   logic            stb;
   logic [3:0]      sel;
   logic [NDUT-1:0] cyc;
   logic [NDUT-1:0] ack;
   logic [NDUT-1:0] err;
   logic [NDUT-1:0] rty;
   logic [31:0]     dout [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      wb_slave_mem #(
         .dwidth      (32),
         .awidth      (32),
         .mem_aw      (4),
         .wait_states (WS[g])
      ) u_dut (
         .clk  (clk),
         .rst  (rst),
         .adr  (adr),
         .din  (din),
         .dout (dout[g]),
         .cyc  (cyc[g]),
         .stb  (stb),
         .we   (we),
         .sel  (sel),
         .ack  (ack[g]),
         .err  (err[g]),
         .rty  (rty[g])
      );
   end

   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        sb [$];
   logic [31:0] mdl [NDUT][16];
   bit          rflag [NDUT];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic one_access(input int k, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             output logic [2:0] kind);
      exp_t        e;
      exp_t        got;
      int          n;
      logic [2:0]  o;
      logic [3:0]  idx;
      idx = a[5:2];
      e.data = '0;
      if ((a >> 6) != 0) begin
         e.kind = T_ERR;
      end else if (RTY_EN && !rflag[k]) begin
         e.kind   = T_RTY;
         rflag[k] = 1'b1;
      end else begin
         e.kind   = T_ACK;
         rflag[k] = 1'b0;
         if (w) begin
            for (int i = 0; i < 4; i++)
               if (s[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
         end else begin
            e.data = mdl[k][idx];
         end
      end
      sb.push_back(e);
      @(negedge clk);
      cyc[k] = 1'b1; stb = 1'b1; we = w; adr = a; din = d; sel = s;
      n = 0;
      o = '0;
      while (o == 3'b000 && n < TMO) begin
         @(posedge clk); #1;
         n++;
         o = {ack[k], err[k], rty[k]};
      end
      cyc[k] = 1'b0; stb = 1'b0; we = 1'b0;
      got = sb.pop_front();
      chk($sformatf("term_d%0d_a%0h", k, a), {29'd0, o}, {29'd0, got.kind});
      chk($sformatf("latency_d%0d", k), n, WS[k] + 1);
      chk($sformatf("dout_d%0d_a%0h", k, a), dout[k], got.data);
      @(posedge clk); #1;
      chk($sformatf("single_d%0d", k), {29'd0, ack[k], err[k], rty[k]}, 32'd0);
      chk($sformatf("dout_idle_d%0d", k), dout[k], 32'd0);
      kind = got.kind;
   endtask

   // Retried accesses are reissued so each call ends in ack or err.
   task automatic access(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
      logic [2:0] kind;
      one_access(k, w, a, d, s, kind);
      if (kind == T_RTY) one_access(k, w, a, d, s, kind);
   endtask

   initial begin
      logic [2:0] acc;
      int         t0, t1, nterm;

      rst = 1'b0; cyc = '0; stb = 1'b0; we = 1'b0; adr = '0; din = '0; sel = '0;
      for (int k = 0; k < NDUT; k++) rflag[k] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("rst_term_d%0d", k), {29'd0, ack[k], err[k], rty[k]}, 32'd0);
         chk($sformatf("rst_dout_d%0d", k), dout[k], 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;

      access(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
      access(0, 1'b0, 32'h4, 32'h0, 4'hF);

      access(0, 1'b1, 32'h8, 32'h11223344, 4'hF);
      access(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'h5);
      access(0, 1'b0, 32'h8, 32'h0, 4'hF);
      chk("mask_model", mdl[0][2], 32'h11BB33DD);
      access(0, 1'b1, 32'h8, 32'h99999999, 4'h0);
      access(0, 1'b0, 32'h8, 32'h0, 4'hF);

      access(0, 1'b1, 32'h0, 32'h01234567, 4'hF);
      access(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
      access(0, 1'b0, 32'h40, 32'h0, 4'hF);
      access(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
      access(0, 1'b0, 32'h0, 32'h0, 4'hF);

      // Abort mid-WAIT on the 3-wait-state instance.
      access(1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h14; din = 32'h0; sel = 4'hF;
      acc = '0;
      repeat (2) begin
         @(posedge clk); #1;
         acc |= {ack[1], err[1], rty[1]};
      end
      cyc[1] = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         acc |= {ack[1], err[1], rty[1]};
      end
      chk("abort_term", {29'd0, acc}, 32'd0);
      access(1, 1'b0, 32'h14, 32'h0, 4'hF);
      access(1, 1'b1, 32'h18, 32'h55AA55AA, 4'hF);
      access(1, 1'b0, 32'h18, 32'h0, 4'hF);

      access(2, 1'b1, 32'h3C, 32'h0BADF00D, 4'hF);
      access(2, 1'b0, 32'h3C, 32'h0, 4'hF);
      access(3, 1'b1, 32'h0, 32'h76543210, 4'hF);
      access(3, 1'b0, 32'h0, 32'h0, 4'hF);

      // Held strobe on the zero-wait instance: terminations two cycles apart.
      @(negedge clk);
      cyc[2] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3C; sel = 4'hF;
      t0 = -1; t1 = -1; nterm = 0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (ack[2] | err[2] | rty[2]) begin
            nterm++;
            if (t0 < 0) t0 = n;
            else if (t1 < 0) t1 = n;
         end
      end
      cyc[2] = 1'b0; stb = 1'b0;
      chk("b2b_first", t0, 1);
      chk("b2b_gap", t1 - t0, 2);
      chk("b2b_count", nterm, 4);
      @(posedge clk); #1;

      // Reset lands on the edge that would commit the write.
      @(negedge clk);
      cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h14; din = 32'h0BADBEEF; sel = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_term", {29'd0, ack[1], err[1], rty[1]}, 32'd0);
      chk("rst_mid_dout", dout[1], 32'd0);
      @(negedge clk);
      rst = 1'b1; cyc[1] = 1'b0; stb = 1'b0; we = 1'b0;
      for (int k = 0; k < NDUT; k++) rflag[k] = 1'b0;
      access(1, 1'b0, 32'h14, 32'h0, 4'hF);

      access(0, 1'b1, 32'hC, 32'h0000005A, 4'hF);
      access(0, 1'b0, 32'hC, 32'h0, 4'hF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
